// File: rtl/counter_sequence_checker_if.sv
// Bundles the checker's stimulus inputs and its status outputs.
// The first_bad signals exist only when CHK_FIRST_BAD_EN is defined.
interface counter_sequence_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 enable;
    logic                 dut_reset;
    logic [WIDTH-1:0]     q_in;
    logic                 locked;
    logic [WIDTH-1:0]     expected;
    logic                 mismatch;
    logic                 wrap_pulse;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef CHK_FIRST_BAD_EN
    logic [WIDTH-1:0]     first_bad;
    logic                 first_bad_vld;
`endif

    modport master (
        output enable, dut_reset, q_in,
        input  locked, expected, mismatch, wrap_pulse, err_count
`ifdef CHK_FIRST_BAD_EN
        , input first_bad, first_bad_vld
`endif
    );

    modport slave (
        input  enable, dut_reset, q_in,
        output locked, expected, mismatch, wrap_pulse, err_count
`ifdef CHK_FIRST_BAD_EN
        , output first_bad, first_bad_vld
`endif
    );
endinterface

// File: rtl/counter_sequence_checker.sv
// Checks that a counter's q follows 0,1,...,2^WIDTH-1,0 with lock/mismatch/wrap reporting.
// Optional first-failure capture is enabled with the CHK_FIRST_BAD_EN macro.
module counter_sequence_checker #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8,
    parameter int SYNC_LEN  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    counter_sequence_checker_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    localparam logic [2:0] SYNC_TGT = 3'(SYNC_LEN);

    state_t               state_q, state_d;
    logic [2:0]           sync_q, sync_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic                 locked_q, locked_d;
    logic                 mismatch_q, mismatch_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 bad;
    logic [WIDTH-1:0]     q_next;

    assign q_next = bus.q_in + WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        sync_d     = sync_q;
        expected_d = expected_q;
        locked_d   = locked_q;
        err_d      = err_q;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        bad        = 1'b0;
        if (!bus.enable) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            sync_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ACQUIRE;
                    expected_d = q_next;
                    sync_d     = '0;
                end
                ACQUIRE: begin
                    if (bus.dut_reset) begin
                        expected_d = '0;
                    end else if (bus.q_in == expected_q) begin
                        sync_d     = sync_q + 3'd1;
                        expected_d = q_next;
                        if (sync_q + 3'd1 == SYNC_TGT) begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        sync_d     = '0;
                        expected_d = q_next;
                    end
                end
                TRACK: begin
                    // A held counter reset must show 0; a bad value is flagged but lock is kept.
                    if (bus.dut_reset) begin
                        expected_d = '0;
                        bad        = (bus.q_in != '0);
                    end else if (bus.q_in == expected_q) begin
                        expected_d = q_next;
                        wrap_d     = (bus.q_in == '0);
                    end else begin
                        bad        = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = ACQUIRE;
                        sync_d     = '0;
                        expected_d = q_next;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (bad) begin
            mismatch_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            expected_q <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            expected_q <= expected_d;
            locked_q   <= locked_d;
            mismatch_q <= mismatch_d;
            wrap_q     <= wrap_d;
            err_q      <= err_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.expected   = expected_q;
    assign bus.mismatch   = mismatch_q;
    assign bus.wrap_pulse = wrap_q;
    assign bus.err_count  = err_q;

`ifdef CHK_FIRST_BAD_EN
    logic [WIDTH-1:0] first_bad_q;
    logic             first_bad_vld_q;

    // Only the very first failure since reset is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first_bad_q     <= '0;
            first_bad_vld_q <= 1'b0;
        end else if (bad && !first_bad_vld_q) begin
            first_bad_q     <= bus.q_in;
            first_bad_vld_q <= 1'b1;
        end
    end

    assign bus.first_bad     = first_bad_q;
    assign bus.first_bad_vld = first_bad_vld_q;
`endif
endmodule

// File: tb/tb_counter_sequence_checker.sv
// Directed bench: two checkers (ERR_CNT_W 8 and 2) see the same counter samples.
// Inputs change on negedge; registered outputs are read at the following negedge.
module tb_counter_sequence_checker;
    logic clk;
    logic reset;
    int   vectors = 0;
    int   errs    = 0;

    counter_sequence_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) ia();
    counter_sequence_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) ib();

    assign ib.enable    = ia.enable;
    assign ib.dut_reset = ia.dut_reset;
    assign ib.q_in      = ia.q_in;

    counter_sequence_checker #(.WIDTH(4), .ERR_CNT_W(8), .SYNC_LEN(2)) u_a (
        .clk(clk), .reset(reset), .bus(ia));
    counter_sequence_checker #(.WIDTH(4), .ERR_CNT_W(2), .SYNC_LEN(2)) u_b (
        .clk(clk), .reset(reset), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [3:0] q, input logic en, input logic dr);
        ia.q_in = q; ia.enable = en; ia.dut_reset = dr;
        @(negedge clk);
    endtask

    task automatic test_reset;
        vectors++; if (ia.locked !== 1'b0) begin errs++; $display("FAIL rst_locked: got %b want 0", ia.locked); end
        vectors++; if (ia.expected !== 4'd0) begin errs++; $display("FAIL rst_expected: got %0d want 0", ia.expected); end
        vectors++; if (ia.mismatch !== 1'b0) begin errs++; $display("FAIL rst_mismatch: got %b want 0", ia.mismatch); end
        vectors++; if (ia.wrap_pulse !== 1'b0) begin errs++; $display("FAIL rst_wrap: got %b want 0", ia.wrap_pulse); end
        vectors++; if (ia.err_count !== 8'd0) begin errs++; $display("FAIL rst_err: got %0d want 0", ia.err_count); end
        vectors++; if (ib.err_count !== 2'd0) begin errs++; $display("FAIL rst_err_b: got %0d want 0", ib.err_count); end
`ifdef CHK_FIRST_BAD_EN
        vectors++; if (ia.first_bad_vld !== 1'b0) begin errs++; $display("FAIL rst_fb_vld: got %b want 0", ia.first_bad_vld); end
`endif
    endtask

    task automatic test_lock;
        apply(4'd0, 1'b0, 1'b0); apply(4'd1, 1'b0, 1'b0); apply(4'd2, 1'b0, 1'b0);
        vectors++; if (ia.expected !== 4'd0) begin errs++; $display("FAIL idle_expected: got %0d want 0", ia.expected); end
        apply(4'd3, 1'b1, 1'b0);
        vectors++; if (ia.expected !== 4'd4) begin errs++; $display("FAIL acq_load: got %0d want 4", ia.expected); end
        vectors++; if (ia.locked !== 1'b0) begin errs++; $display("FAIL acq_locked0: got %b want 0", ia.locked); end
        apply(4'd4, 1'b1, 1'b0);
        vectors++; if (ia.locked !== 1'b0) begin errs++; $display("FAIL acq_locked1: got %b want 0", ia.locked); end
        apply(4'd5, 1'b1, 1'b0);
        vectors++; if (ia.locked !== 1'b1) begin errs++; $display("FAIL lock: got %b want 1", ia.locked); end
        vectors++; if (ia.expected !== 4'd6) begin errs++; $display("FAIL lock_expected: got %0d want 6", ia.expected); end
    endtask

    task automatic test_run_wrap;
        logic [3:0] q;
        for (int i = 0; i < 40; i++) begin
            q = 4'(6 + i);
            apply(q, 1'b1, 1'b0);
            vectors++; if (ia.mismatch !== 1'b0) begin errs++; $display("FAIL run_mismatch q=%0d: got %b want 0", q, ia.mismatch); end
            vectors++; if (ia.locked !== 1'b1) begin errs++; $display("FAIL run_locked q=%0d: got %b want 1", q, ia.locked); end
            vectors++; if (ia.expected !== 4'(q + 4'd1)) begin errs++; $display("FAIL run_expected q=%0d: got %0d want %0d", q, ia.expected, 4'(q + 4'd1)); end
            vectors++; if (ia.wrap_pulse !== (q == 4'd0)) begin errs++; $display("FAIL run_wrap q=%0d: got %b want %b", q, ia.wrap_pulse, q == 4'd0); end
        end
    endtask

    task automatic test_mismatch;
        for (int v = 14; v < 23; v++) apply(4'(v), 1'b1, 1'b0);
        apply(4'd9, 1'b1, 1'b0);
        vectors++; if (ia.mismatch !== 1'b1) begin errs++; $display("FAIL mm_pulse: got %b want 1", ia.mismatch); end
        vectors++; if (ia.err_count !== 8'd1) begin errs++; $display("FAIL mm_err: got %0d want 1", ia.err_count); end
        vectors++; if (ib.err_count !== 2'd1) begin errs++; $display("FAIL mm_err_b: got %0d want 1", ib.err_count); end
        vectors++; if (ia.locked !== 1'b0) begin errs++; $display("FAIL mm_unlock: got %b want 0", ia.locked); end
        vectors++; if (ia.expected !== 4'd10) begin errs++; $display("FAIL mm_expected: got %0d want 10", ia.expected); end
`ifdef CHK_FIRST_BAD_EN
        vectors++; if (ia.first_bad !== 4'd9 || ia.first_bad_vld !== 1'b1) begin errs++; $display("FAIL fb_capture: got %0d/%b want 9/1", ia.first_bad, ia.first_bad_vld); end
`endif
        apply(4'd10, 1'b1, 1'b0);
        vectors++; if (ia.mismatch !== 1'b0) begin errs++; $display("FAIL mm_one_cycle: got %b want 0", ia.mismatch); end
        vectors++; if (ia.locked !== 1'b0) begin errs++; $display("FAIL relock_early: got %b want 0", ia.locked); end
        apply(4'd11, 1'b1, 1'b0);
        vectors++; if (ia.locked !== 1'b1) begin errs++; $display("FAIL relock: got %b want 1", ia.locked); end
        vectors++; if (ia.expected !== 4'd12) begin errs++; $display("FAIL relock_expected: got %0d want 12", ia.expected); end
    endtask

    task automatic test_dut_reset;
        apply(4'd0, 1'b1, 1'b1); apply(4'd0, 1'b1, 1'b1);
        vectors++; if (ia.mismatch !== 1'b0 || ia.locked !== 1'b1) begin errs++; $display("FAIL dr_clean: got mm=%b lk=%b want 0/1", ia.mismatch, ia.locked); end
        vectors++; if (ia.expected !== 4'd0) begin errs++; $display("FAIL dr_expected: got %0d want 0", ia.expected); end
        apply(4'd0, 1'b1, 1'b0);
        vectors++; if (ia.expected !== 4'd1 || ia.mismatch !== 1'b0) begin errs++; $display("FAIL dr_resume0: got exp=%0d mm=%b want 1/0", ia.expected, ia.mismatch); end
        apply(4'd1, 1'b1, 1'b0); apply(4'd2, 1'b1, 1'b0);
        vectors++; if (ia.expected !== 4'd3 || ia.locked !== 1'b1 || ia.mismatch !== 1'b0) begin errs++; $display("FAIL dr_resume2: got exp=%0d lk=%b mm=%b want 3/1/0", ia.expected, ia.locked, ia.mismatch); end
        apply(4'd5, 1'b1, 1'b1);
        vectors++; if (ia.mismatch !== 1'b1) begin errs++; $display("FAIL dr_bad_pulse: got %b want 1", ia.mismatch); end
        vectors++; if (ia.err_count !== 8'd2) begin errs++; $display("FAIL dr_bad_err: got %0d want 2", ia.err_count); end
        vectors++; if (ia.locked !== 1'b1 || ia.expected !== 4'd0) begin errs++; $display("FAIL dr_bad_hold: got lk=%b exp=%0d want 1/0", ia.locked, ia.expected); end
`ifdef CHK_FIRST_BAD_EN
        vectors++; if (ia.first_bad !== 4'd9 || ia.first_bad_vld !== 1'b1) begin errs++; $display("FAIL fb_sticky: got %0d/%b want 9/1", ia.first_bad, ia.first_bad_vld); end
`endif
        apply(4'd0, 1'b1, 1'b1); apply(4'd0, 1'b1, 1'b0); apply(4'd1, 1'b1, 1'b0);
        vectors++; if (ia.expected !== 4'd2 || ia.locked !== 1'b1 || ia.mismatch !== 1'b0) begin errs++; $display("FAIL dr_after_bad: got exp=%0d lk=%b mm=%b want 2/1/0", ia.expected, ia.locked, ia.mismatch); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            apply(4'd5, 1'b1, 1'b1);
            vectors++; if (ia.mismatch !== 1'b1 || ib.mismatch !== 1'b1) begin errs++; $display("FAIL sat_pulse%0d: got %b/%b want 1/1", i, ia.mismatch, ib.mismatch); end
            vectors++; if (ia.err_count !== 8'(3 + i)) begin errs++; $display("FAIL sat_err_a%0d: got %0d want %0d", i, ia.err_count, 3 + i); end
            vectors++; if (ib.err_count !== 2'd3) begin errs++; $display("FAIL sat_err_b%0d: got %0d want 3", i, ib.err_count); end
            apply(4'd0, 1'b1, 1'b1);
            vectors++; if (ib.mismatch !== 1'b0 || ib.locked !== 1'b1) begin errs++; $display("FAIL sat_gap%0d: got mm=%b lk=%b want 0/1", i, ib.mismatch, ib.locked); end
        end
        apply(4'd0, 1'b1, 1'b0); apply(4'd1, 1'b1, 1'b0);
        vectors++; if (ib.locked !== 1'b1 || ib.expected !== 4'd2) begin errs++; $display("FAIL sat_track: got lk=%b exp=%0d want 1/2", ib.locked, ib.expected); end
    endtask

    task automatic test_reset_mid;
        #3 reset = 1'b0;
        #1;
        vectors++; if (ia.locked !== 1'b0 || ia.expected !== 4'd0 || ia.err_count !== 8'd0) begin errs++; $display("FAIL async_rst_a: got lk=%b exp=%0d err=%0d want 0/0/0", ia.locked, ia.expected, ia.err_count); end
        vectors++; if (ib.locked !== 1'b0 || ib.err_count !== 2'd0 || ib.mismatch !== 1'b0) begin errs++; $display("FAIL async_rst_b: got lk=%b err=%0d mm=%b want 0/0/0", ib.locked, ib.err_count, ib.mismatch); end
`ifdef CHK_FIRST_BAD_EN
        vectors++; if (ia.first_bad_vld !== 1'b0 || ia.first_bad !== 4'd0) begin errs++; $display("FAIL async_rst_fb: got %0d/%b want 0/0", ia.first_bad, ia.first_bad_vld); end
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_enable_off;
        apply(4'd3, 1'b1, 1'b0); apply(4'd4, 1'b1, 1'b0); apply(4'd5, 1'b1, 1'b0);
        vectors++; if (ia.locked !== 1'b1) begin errs++; $display("FAIL en_lock: got %b want 1", ia.locked); end
        apply(4'd6, 1'b0, 1'b0);
        vectors++; if (ia.locked !== 1'b0 || ia.expected !== 4'd6) begin errs++; $display("FAIL en_off: got lk=%b exp=%0d want 0/6", ia.locked, ia.expected); end
        apply(4'd9, 1'b0, 1'b0);
        vectors++; if (ia.mismatch !== 1'b0 || ia.expected !== 4'd6 || ia.err_count !== 8'd0) begin errs++; $display("FAIL en_idle_hold: got mm=%b exp=%0d err=%0d want 0/6/0", ia.mismatch, ia.expected, ia.err_count); end
        apply(4'd9, 1'b1, 1'b0);
        vectors++; if (ia.expected !== 4'd10 || ia.locked !== 1'b0) begin errs++; $display("FAIL en_reacquire: got exp=%0d lk=%b want 10/0", ia.expected, ia.locked); end
    endtask

    initial begin
        reset = 1'b0;
        ia.enable = 1'b0; ia.dut_reset = 1'b0; ia.q_in = 4'd0;
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        test_lock();
        test_run_wrap();
        test_mismatch();
        test_dut_reset();
        test_saturation();
        test_reset_mid();
        test_enable_off();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
